// File: rtl/sseg_event_counter.sv
// sseg_event_counter: counts synchronised EVENT rising edges and scans the count
// onto common-anode seven-segment digits in hex or decimal (double-dabble).
module sseg_event_counter #(
    parameter int CNT_WIDTH   = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EVENT,
    input  logic                 CLR,
    input  logic                 HOLD,
    input  logic                 MODE,
    input  logic                 SAT,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 CONV_BUSY,
    output logic [7:0]           CATHODES,
    output logic [DIGITS-1:0]    ANODES
);
    localparam int ND = (CNT_WIDTH + 2) / 3;
    localparam int BW = 4 * ND;
    localparam int DW = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(CNT_WIDTH);
    localparam logic [63:0] DEC_LIM = 64'(10 ** DIGITS);
    localparam logic [7:0] SEGS [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic s1, s2, ev_d, pulse;
    state_t state, state_n;
    logic [CNT_WIDTH-1:0] bin;
    logic [BW-1:0] bcd, bcd_add;
    logic [SW-1:0] bit_cnt;
    logic snap_ovf;
    logic [DW-1:0] disp;
    logic disp_ovf, hex_ovf, tc;
    logic [RW-1:0] rc;
    logic [IW-1:0] idx, idx_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            ev_d  <= 1'b0;
            pulse <= 1'b0;
            COUNT <= '0;
        end else begin
            s1    <= EVENT;
            s2    <= s1;
            ev_d  <= s2;
            pulse <= s2 & ~ev_d;
            COUNT <= CLR ? '0 : !pulse ? COUNT : &COUNT ? (SAT ? COUNT : '0) : COUNT + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_n = state == IDLE  ? LOAD :
                  state == LOAD  ? SHIFT :
                  state == SHIFT ? (bit_cnt == SW'(CNT_WIDTH - 1) ? DONE : SHIFT) : IDLE;
        bcd_add = bcd;
        for (int k = 0; k < ND; k++)
            bcd_add[4*k +: 4] = bcd[4*k +: 4] >= 4'd5 ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end

    assign CONV_BUSY = state == LOAD || state == SHIFT;
    assign hex_ovf   = (64'(COUNT) >> DW) != 64'd0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            snap_ovf <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                bin      <= COUNT;
                snap_ovf <= 64'(COUNT) >= DEC_LIM;
            end
            if (state == LOAD) begin
                bcd     <= '0;
                bit_cnt <= '0;
            end
            if (state == SHIFT) begin
                {bcd, bin} <= {bcd_add, bin} << 1;
                bit_cnt    <= bit_cnt + SW'(1);
            end
        end
    end

    // Display register: hex follows COUNT every cycle, decimal takes each finished conversion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else if (!HOLD) begin
            if (!MODE) begin
                disp     <= DW'(COUNT);
                disp_ovf <= hex_ovf;
            end else if (state == DONE) begin
                disp     <= DW'(bcd);
                disp_ovf <= snap_ovf;
            end
        end
    end

    assign tc    = rc == RW'(REFRESH_DIV - 1);
    assign idx_n = !tc ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);

    // Outputs are driven from the next index so the first dwell after reset is exact.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rc       <= '0;
            idx      <= '0;
            ANODES   <= ~DIGITS'(1);
            CATHODES <= 8'hC0;
        end else begin
            rc       <= tc ? '0 : rc + RW'(1);
            idx      <= idx_n;
            ANODES   <= ~(DIGITS'(1) << idx_n);
            CATHODES <= disp_ovf ? 8'hBF : SEGS[disp[4*idx_n +: 4]];
        end
    end
endmodule

// File: doc/sseg_event_counter.md
# sseg_event_counter

Parametrised event counter with a multiplexed seven-segment display driver. It counts rising edges of an asynchronous event input, such as a RAT output-port bit. The count is shown on DIGITS common-anode digits in hex or decimal, with a sequential binary-to-BCD converter for decimal. It sits in the board-level wrapper beside the RAT MCU and replaces the ad-hoc counter-plus-display glue.

## Interface
- CNT_WIDTH, 16, counter width in bits (4..32)
- DIGITS, 4, number of display digits (1..8)
- REFRESH_DIV, 100000, CLK cycles each digit is lit before advancing (>=2)
- CLK  in  1  system clock; all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- EVENT  in  1  asynchronous event; each 0->1 transition counts once
- CLR  in  1  synchronous count clear
- HOLD  in  1  1 = freeze displayed value; counting continues
- MODE  in  1  0 = hex, 1 = decimal
- SAT  in  1  1 = saturate at max, 0 = wrap to 0
- COUNT  out  CNT_WIDTH  current count
- CONV_BUSY  out  1  BCD converter running
- CATHODES  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- ANODES  out  DIGITS  active-low one-hot digit select; bit 0 = rightmost

## Operation
- EVENT path: EVENT passes through a 2-flop synchroniser, then a registered edge detector. One pulse per synchronised 0->1 edge.
- Count update, priority high to low:
  - CLR: COUNT=0; a simultaneous edge is dropped.
  - Edge with COUNT < 2^CNT_WIDTH-1: increment.
  - Edge at max with SAT=1: hold max.
  - Edge at max with SAT=0: wrap to 0.
- Converter FSM (double-dabble), runs continuously:
  - IDLE -> LOAD: snapshot COUNT.
  - LOAD -> SHIFT: exactly CNT_WIDTH cycles of add-3-then-shift.
  - SHIFT -> DONE: publish BCD result.
  - DONE -> IDLE.
  - CONV_BUSY=1 in LOAD and SHIFT.
- Display register, one nibble per digit:
  - Loads only when HOLD=0.
  - MODE=0: loads every cycle from COUNT, zero-extended or truncated to 4*DIGITS bits.
  - MODE=1: loads in DONE from BCD result.
- Overflow: if the value is not representable in DIGITS digits, every digit shows dash (8'hBF).
  - Hex overflow: COUNT >= 16^DIGITS.
  - Decimal overflow: snapshot >= 10^DIGITS.
- MODE change: takes effect at the next display load, with no glitch beyond one stale frame.
- Scan:
  - Refresh counter 0..REFRESH_DIV-1; digit index advances on its terminal count, wraps DIGITS-1 -> 0.
  - ANODES = ~(1<<index).
  - CATHODES = segment decode of the indexed nibble.
  - Decode is hex 0-F; decimal never produces A-F. dp is always off (1).
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Reset (RST_N=0, async):
  - COUNT=0, display register=0, converter IDLE, CONV_BUSY=0.
  - Refresh counter=0, index=0, ANODES=~1 (4'b1110 for 4 digits), CATHODES=8'hC0.
- Reset mid-conversion aborts; the partial result is discarded.
- EVENT rise sampled at edge k -> COUNT updates at edge k+3. Minimum EVENT high and low time is 2 CLK cycles to guarantee a count.
- Hex latency: COUNT change -> display register next edge.
- Decimal latency: COUNT change -> display within 2*(CNT_WIDTH+3) cycles worst case.
- Conversion period: CNT_WIDTH+3 cycles per snapshot.
- Digit dwell: exactly REFRESH_DIV cycles; frame = DIGITS*REFRESH_DIV cycles.
- ANODES and CATHODES are registered, so both change on the same edge with no mixed-digit cycle.
- HOLD rising: display freezes from the next edge. HOLD falling: display resumes at the next load.

## Test plan
- Reset: RST_N low mid-scan and mid-SHIFT -> outputs immediately at reset values (COUNT=0, ANODES=4'b1110, CATHODES=C0, CONV_BUSY=0); after release the first conversion completes in 19 cycles.
- Counting latency: defaults with REFRESH_DIV=4, MODE=0, 5 clean EVENT pulses (3 high / 3 low) -> COUNT=5, each increment 3 cycles after its rise; scan shows digit 0 = 92 and digits 1-3 = C0, each lit 4 cycles.
- Decimal: force COUNT to 1234 via pulses, MODE=1 -> within 38 cycles the digits read 1,2,3,4 (F9,A4,B0,99) left to right; CONV_BUSY high 17 of every 19 cycles.
- Wrap and saturate: CNT_WIDTH=4, DIGITS=1, COUNT=15.
  - SAT=1: one edge -> COUNT stays 15, hex display 8E.
  - SAT=0: one edge -> COUNT=0.
- Overflow: MODE=1, COUNT=10000 -> all four digits BF. MODE=0 -> hex 2710 shown (A4,F8,F9,C0).
- CLR and HOLD: CLR asserted in the same cycle as an edge -> COUNT=0. HOLD=1 at 42, then 3 events -> COUNT=45 with display still 42 (hex 2A); HOLD=0 -> display 2D.
